// File: rtl/dflow_mem_sched.sv
// dflow_mem_sched: arbitrates a write requester and a read requester onto a
// single memory command port. Grants come in bursts per direction, a one-cycle
// TURN bubble separates direction changes, and a burst is capped at MAX_BURST
// only while the opposite side is waiting.
module dflow_mem_sched #(
    parameter int MEM_ADDR_WIDTH = 19,
    parameter int MEM_DATA_WIDTH = 144,
    parameter int MAX_BURST      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sw_rst,
    input  logic                      cal_done,
    input  logic                      wr_req,
    input  logic [MEM_ADDR_WIDTH-1:0] wr_addr,
    input  logic [MEM_DATA_WIDTH-1:0] wr_data,
    output logic                      wr_ack,
    input  logic                      rd_req,
    input  logic [MEM_ADDR_WIDTH-1:0] rd_addr,
    output logic                      rd_ack,
    input  logic                      mem_rdy,
    output logic                      mem_cmd_valid,
    output logic                      mem_cmd_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_wdata,
    output logic [31:0]               cmd_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    state_t     state_r;
    logic       last_dir_r;   // 1 = write
    logic       pend_dir_r;   // direction entered when TURN completes
    logic [7:0] burst_cnt_r;

    logic reset_s;
    logic ready_s;
    logic cap_s;
    logic wr_switch_s;
    logic rd_switch_s;
    logic wr_acc_s;
    logic rd_acc_s;
    logic tgt_valid_s;
    logic tgt_wr_s;

    // Acceptance and switch decisions; a cycle that leaves for TURN grants nothing,
    // so a capped burst never exceeds MAX_BURST commands.
    always_comb begin
        reset_s     = rst | sw_rst;
        ready_s     = mem_rdy & cal_done;
        cap_s       = (burst_cnt_r == MAX_BURST_C);
        wr_switch_s = rd_req & (cap_s | ~wr_req);
        rd_switch_s = wr_req & (cap_s | ~rd_req);
        wr_acc_s    = (state_r == ST_WR) & wr_req & ready_s & ~wr_switch_s & ~reset_s;
        rd_acc_s    = (state_r == ST_RD) & rd_req & ready_s & ~rd_switch_s & ~reset_s;
        wr_ack      = wr_acc_s;
        rd_ack      = rd_acc_s;
    end

    // Direction chosen from IDLE; contention favours the side not served last.
    always_comb begin
        tgt_valid_s = 1'b0;
        tgt_wr_s    = last_dir_r;
        if (wr_req && rd_req) begin
            tgt_valid_s = 1'b1;
            tgt_wr_s    = ~last_dir_r;
        end else if (wr_req) begin
            tgt_valid_s = 1'b1;
            tgt_wr_s    = 1'b1;
        end else if (rd_req) begin
            tgt_valid_s = 1'b1;
            tgt_wr_s    = 1'b0;
        end else begin
            tgt_valid_s = 1'b0;
            tgt_wr_s    = last_dir_r;
        end
    end

    // Scheduler FSM, burst counter and registered memory command outputs.
    always_ff @(posedge clk) begin
        if (reset_s) begin
            state_r       <= ST_IDLE;
            last_dir_r    <= 1'b1;
            pend_dir_r    <= 1'b1;
            burst_cnt_r   <= 8'd0;
            cmd_cnt       <= 32'd0;
            mem_cmd_valid <= 1'b0;
            mem_cmd_we    <= 1'b0;
            mem_addr      <= {MEM_ADDR_WIDTH{1'b0}};
            mem_wdata     <= {MEM_DATA_WIDTH{1'b0}};
        end else begin
            mem_cmd_valid <= wr_acc_s | rd_acc_s;
            cmd_cnt       <= cmd_cnt + {31'd0, mem_cmd_valid};
            if (wr_acc_s) begin
                mem_cmd_we <= 1'b1;
                mem_addr   <= wr_addr;
                mem_wdata  <= wr_data;
            end else if (rd_acc_s) begin
                mem_cmd_we <= 1'b0;
                mem_addr   <= rd_addr;
                mem_wdata  <= {MEM_DATA_WIDTH{1'b0}};
            end
            case (state_r)
                ST_IDLE: begin
                    if (tgt_valid_s) begin
                        if (tgt_wr_s == last_dir_r) begin
                            state_r     <= tgt_wr_s ? ST_WR : ST_RD;
                            burst_cnt_r <= 8'd0;
                        end else begin
                            state_r    <= ST_TURN;
                            pend_dir_r <= tgt_wr_s;
                        end
                    end
                end
                ST_WR: begin
                    if (wr_switch_s) begin
                        state_r    <= ST_TURN;
                        pend_dir_r <= 1'b0;
                    end else if (!wr_req && !rd_req) begin
                        state_r <= ST_IDLE;
                    end else if (wr_acc_s && !cap_s) begin
                        burst_cnt_r <= burst_cnt_r + 8'd1;
                    end
                end
                ST_RD: begin
                    if (rd_switch_s) begin
                        state_r    <= ST_TURN;
                        pend_dir_r <= 1'b1;
                    end else if (!wr_req && !rd_req) begin
                        state_r <= ST_IDLE;
                    end else if (rd_acc_s && !cap_s) begin
                        burst_cnt_r <= burst_cnt_r + 8'd1;
                    end
                end
                ST_TURN: begin
                    state_r     <= pend_dir_r ? ST_WR : ST_RD;
                    last_dir_r  <= pend_dir_r;
                    burst_cnt_r <= 8'd0;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
